// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//   Slave end of the RV32I core's load/store memory interface. Accepts one
//   request at a time (valid/ready), performs a byte/half/word load or store
//   on an internal word array after LATENCY cycles, and returns sign/zero
//   extended load data or an error flag over a valid/ready response channel.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous reset, active-low
//   req_valid   request present
//   req_ready   responder can accept a request (registered)
//   req_we      1 = store, 0 = load
//   req_addr    byte address
//   req_funct3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   req_wdata   store data
//   rsp_valid   response present (registered)
//   rsp_ready   core accepts response
//   rsp_rdata   load result, 0 for stores and errors (registered)
//   rsp_err     misaligned access or illegal funct3 (registered)
// -----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [2:0]            req_funct3,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);

    localparam int unsigned IDX_W = ADDR_WIDTH - 2;
    localparam int unsigned DEPTH = 2 ** IDX_W;
    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [2:0]            r_funct3;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_req_ready;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [1:0]            w_state_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic                  w_accept;
    logic                  w_commit;

    logic                  w_a_we;
    logic [ADDR_WIDTH-1:0] w_a_addr;
    logic [2:0]            w_a_f3;
    logic [DATA_WIDTH-1:0] w_a_wdata;

    logic [IDX_W-1:0]      w_idx;
    logic [1:0]            w_lane;
    logic [DATA_WIDTH-1:0] w_word;
    logic [DATA_WIDTH-1:0] w_byte_sh;
    logic [DATA_WIDTH-1:0] w_half_sh;
    logic                  w_legal;
    logic                  w_misal;
    logic                  w_err;
    logic [DATA_WIDTH-1:0] w_load;
    logic [3:0]            w_be;
    logic [DATA_WIDTH-1:0] w_wd;

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

    assign w_accept = (r_state == S_IDLE) && req_valid && r_req_ready;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic; w_commit marks the edge that enters RESP
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (LATENCY == 1) begin
                        w_state_nxt = S_RESP;
                        w_commit    = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = S_RESP;
                    w_commit    = 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // With LATENCY=1 the commit happens on the accept edge, so use live inputs
    always_comb begin
        if (r_state == S_IDLE) begin
            w_a_we    = req_we;
            w_a_addr  = req_addr;
            w_a_f3    = req_funct3;
            w_a_wdata = req_wdata;
        end else begin
            w_a_we    = r_we;
            w_a_addr  = r_addr;
            w_a_f3    = r_funct3;
            w_a_wdata = r_wdata;
        end
    end

    assign w_idx     = w_a_addr[ADDR_WIDTH-1:2];
    assign w_lane    = w_a_addr[1:0];
    assign w_word    = r_mem[w_idx];
    assign w_byte_sh = w_word >> {w_lane, 3'b000};
    assign w_half_sh = w_word >> {w_a_addr[1], 4'b0000};

    // Legality, alignment, load extraction and store lane selection
    always_comb begin
        w_legal = 1'b0;
        w_misal = 1'b0;
        w_load  = '0;
        w_be    = 4'b0000;
        w_wd    = '0;
        if (w_a_we) begin
            w_legal = w_a_f3 inside {3'b000, 3'b001, 3'b010};
        end else begin
            w_legal = w_a_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        end
        case (w_a_f3[1:0])
            2'b00: begin
                w_load = w_a_f3[2] ? {24'h0, w_byte_sh[7:0]}
                                   : {{24{w_byte_sh[7]}}, w_byte_sh[7:0]};
                w_be   = 4'b0001 << w_lane;
                w_wd   = {4{w_a_wdata[7:0]}};
            end
            2'b01: begin
                w_misal = w_a_addr[0];
                w_load  = w_a_f3[2] ? {16'h0, w_half_sh[15:0]}
                                    : {{16{w_half_sh[15]}}, w_half_sh[15:0]};
                w_be    = w_a_addr[1] ? 4'b1100 : 4'b0011;
                w_wd    = {2{w_a_wdata[15:0]}};
            end
            2'b10: begin
                w_misal = (w_lane != 2'b00);
                w_load  = w_word;
                w_be    = 4'b1111;
                w_wd    = w_a_wdata;
            end
            default: begin
                w_misal = 1'b0;
            end
        endcase
    end

    assign w_err = !w_legal || w_misal;

    // Array: not reset; written only on the commit edge of a legal store
    always_ff @(posedge clk) begin
        if (w_commit && w_a_we && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wd[8*b +: 8];
                end
            end
        end
    end

    // Request capture and registered handshake/response outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_funct3    <= '0;
            r_wdata     <= '0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_req_ready <= (w_state_nxt == S_IDLE);
            if (w_accept) begin
                r_we     <= req_we;
                r_addr   <= req_addr;
                r_funct3 <= req_funct3;
                r_wdata  <= req_wdata;
            end
            if (w_commit) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= w_err;
                r_rsp_rdata <= (w_err || w_a_we) ? '0 : w_load;
            end else if ((r_state == S_RESP) && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//   Table-driven bench for data_mem_responder (LATENCY=2). Expected responses
//   are pushed to a scoreboard queue when a request is driven and popped when
//   the response appears. Hand-written sequences cover back-pressure and reset
//   during an outstanding request.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 12;
    localparam int unsigned LAT = 2;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [2:0]    f3;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
    } vec_t;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [2:0]    req_funct3;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    int   n_cmp;
    int   n_bad;
    vec_t tbl[$];
    exp_t sb[$];

    data_mem_responder #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .LATENCY    (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_funct3 (req_funct3),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic we, input logic [AW-1:0] addr, input logic [2:0] f3,
                       input logic [DW-1:0] wdata, input logic [DW-1:0] er, input logic ee);
        vec_t v;
        v.we = we; v.addr = addr; v.f3 = f3; v.wdata = wdata;
        v.exp_rdata = er; v.exp_err = ee;
        tbl.push_back(v);
    endtask

    // One request/response transaction; hold = cycles of rsp_ready=0 back-pressure
    task automatic xact(input string nm, input vec_t v, input int hold);
        int   n;
        exp_t e;
        logic [DW-1:0] first_rdata;
        logic          first_err;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_addr   = v.addr;
        req_funct3 = v.f3;
        req_wdata  = v.wdata;
        rsp_ready  = (hold == 0);
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk({nm, "_accept_timeout"}, 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        e.rdata = v.exp_rdata;
        e.err   = v.exp_err;
        sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = ~v.addr;
        req_wdata = ~v.wdata;
        chk({nm, "_ready_low"}, 32'(req_ready), 32'd0);
        n = 1;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_latency"}, 32'(n), 32'(LAT));
        if (!rsp_valid) return;
        if (sb.size() == 0) begin
            chk({nm, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        chk({nm, "_rdata"}, rsp_rdata, e.rdata);
        chk({nm, "_err"}, 32'(rsp_err), 32'(e.err));
        first_rdata = rsp_rdata;
        first_err   = rsp_err;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk($sformatf("%s_hold%0d_valid", nm, k), 32'(rsp_valid), 32'd1);
            chk($sformatf("%s_hold%0d_rdata", nm, k), rsp_rdata, first_rdata);
            chk($sformatf("%s_hold%0d_err", nm, k), 32'(rsp_err), 32'(first_err));
            chk($sformatf("%s_hold%0d_rdy", nm, k), 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk({nm, "_valid_drop"}, 32'(rsp_valid), 32'd0);
        chk({nm, "_idle_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        vec_t v;
        n_cmp      = 0;
        n_bad      = 0;
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_funct3 = '0;
        req_wdata  = '0;
        rsp_ready  = 1'b1;

        //   we    addr     f3      wdata          rdata          err
        add(1'b1, 12'h010, 3'b010, 32'hDEADBEEF, 32'h00000000, 1'b0);
        add(1'b0, 12'h010, 3'b010, 32'h0,        32'hDEADBEEF, 1'b0);
        add(1'b0, 12'h013, 3'b000, 32'h0,        32'hFFFFFFDE, 1'b0);
        add(1'b0, 12'h013, 3'b100, 32'h0,        32'h000000DE, 1'b0);
        add(1'b0, 12'h012, 3'b101, 32'h0,        32'h0000DEAD, 1'b0);
        add(1'b0, 12'h010, 3'b001, 32'h0,        32'hFFFFBEEF, 1'b0);
        add(1'b1, 12'h011, 3'b001, 32'h00001234, 32'h00000000, 1'b1);
        add(1'b0, 12'h010, 3'b010, 32'h0,        32'hDEADBEEF, 1'b0);
        add(1'b0, 12'h010, 3'b011, 32'h0,        32'h00000000, 1'b1);
        add(1'b1, 12'h012, 3'b000, 32'h00000055, 32'h00000000, 1'b0);
        add(1'b0, 12'h010, 3'b010, 32'h0,        32'hDE55BEEF, 1'b0);
        add(1'b0, 12'h012, 3'b000, 32'h0,        32'h00000055, 1'b0);
        add(1'b0, 12'h011, 3'b001, 32'h0,        32'h00000000, 1'b1);
        add(1'b0, 12'h012, 3'b010, 32'h0,        32'h00000000, 1'b1);
        add(1'b1, 12'h010, 3'b011, 32'h11111111, 32'h00000000, 1'b1);
        add(1'b1, 12'h010, 3'b100, 32'h22222222, 32'h00000000, 1'b1);
        add(1'b0, 12'h010, 3'b010, 32'h0,        32'hDE55BEEF, 1'b0);
        add(1'b1, 12'hFFF, 3'b000, 32'h000000AA, 32'h00000000, 1'b0);
        add(1'b0, 12'hFFF, 3'b000, 32'h0,        32'hFFFFFFAA, 1'b0);
        add(1'b0, 12'hFFF, 3'b100, 32'h0,        32'h000000AA, 1'b0);
        add(1'b1, 12'h020, 3'b010, 32'h11223344, 32'h00000000, 1'b0);

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < tbl.size(); i++) begin
            xact($sformatf("v%0d", i), tbl[i], 0);
        end

        // Back-pressure: response held stable while rsp_ready is low
        v.we = 1'b0; v.addr = 12'h010; v.f3 = 3'b010; v.wdata = '0;
        v.exp_rdata = 32'hDE55BEEF; v.exp_err = 1'b0;
        xact("bp", v, 5);

        // Reset during WAIT drops the store and produces no response
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_addr   = 12'h020;
        req_funct3 = 3'b010;
        req_wdata  = 32'hCAFEF00D;
        rsp_ready  = 1'b1;
        chk("mr_ready_before", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        rst       = 1'b0;
        @(negedge clk);
        chk("mr_no_rsp_in_rst", 32'(rsp_valid), 32'd0);
        chk("mr_ready_in_rst", 32'(req_ready), 32'd0);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("mr_no_rsp%0d", k), 32'(rsp_valid), 32'd0);
        end
        v.we = 1'b0; v.addr = 12'h020; v.f3 = 3'b010; v.wdata = '0;
        v.exp_rdata = 32'h11223344; v.exp_err = 1'b0;
        xact("mr_lw", v, 0);

        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
